// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
//
// Shares one bank of DEPTH x Width flip-flop registers between NREQ write
// requesters. A round-robin arbiter picks one requester per transaction and
// uses a Req/Gnt/Ack handshake. The bank also has one registered read port.
// This block is the only writer of the bank.
//
// Transaction timeline (IDLE -> WRITE -> IDLE):
//   edge 1 : winner sampled, Gnt one-hot, address/data latched, Busy=1
//   edge 2 : bank written from the latched values, Ack pulses, Gnt/Busy drop
//
// Ports:
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   Req      in   [NREQ]        write request per requester
//   Data_in  in   [NREQ*Width]  write data, requester i at [i*Width +: Width]
//   Addr_in  in   [NREQ*AW]     write address, requester i at [i*AW +: AW]
//   Clr      in   synchronous clear of the whole bank
//   Rd_addr  in   [AW]          read address
//   Gnt      out  [NREQ]        registered one-hot grant
//   Ack      out  [NREQ]        one-cycle one-hot write-completion pulse
//   Busy     out  high while the FSM is in WRITE
//   Rd_data  out  [Width]       registered read data
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
  parameter int Width = 4,
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       Req,
  input  logic [NREQ*Width-1:0] Data_in,
  input  logic [NREQ*AW-1:0]    Addr_in,
  input  logic                  Clr,
  input  logic [AW-1:0]         Rd_addr,
  output logic [NREQ-1:0]       Gnt,
  output logic [NREQ-1:0]       Ack,
  output logic                  Busy,
  output logic [Width-1:0]      Rd_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic [PW-1:0]     ptr_reg;
  logic [PW-1:0]     win_reg;
  logic [AW-1:0]     lat_addr_reg;
  logic [Width-1:0]  lat_data_reg;
  logic [Width-1:0]  rd_data_reg;
  logic [Width-1:0]  bank_reg [DEPTH];

  logic [Width-1:0]  req_data [NREQ];
  logic [AW-1:0]     req_addr [NREQ];

  logic              found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;
  logic              capture;
  logic              commit;
  logic [Width-1:0]  rd_mux;

  // Unpack the flat per-requester buses.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_data[gi] = Data_in[gi*Width +: Width];
      assign req_addr[gi] = Addr_in[gi*AW +: AW];
    end
  endgenerate

  // Round-robin search starting just after the last served requester, so the
  // requester served most recently ends up with the lowest priority.
  always_comb begin
    found   = 1'b0;
    win_idx = ptr_reg;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_reg) + k) % NREQ);
      if (!found && Req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_next = state_reg;
    gnt_next   = '0;
    ack_next   = '0;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next   = NREQ'(1) << win_idx;
          capture    = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        ack_next   = gnt_reg;
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      ack_reg      <= '0;
      ptr_reg      <= PW'(NREQ - 1);
      win_reg      <= '0;
      lat_addr_reg <= '0;
      lat_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      if (capture) begin
        win_reg      <= win_idx;
        lat_addr_reg <= req_addr[win_idx];
        lat_data_reg <= req_data[win_idx];
      end
      if (commit) begin
        ptr_reg <= win_reg;
      end
    end
  end

  // One flop group per register. An out-of-range latched address matches no
  // register, so that write is silently dropped. Clr overrides a same-edge
  // commit.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bank
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          bank_reg[gi] <= '0;
        end else if (Clr) begin
          bank_reg[gi] <= '0;
        end else if (commit && (lat_addr_reg == AW'(gi))) begin
          bank_reg[gi] <= lat_data_reg;
        end
      end
    end
  endgenerate

  // Read mux sees the pre-edge bank contents, giving read-before-write and
  // read-before-clear behaviour. Out-of-range addresses return zero.
  always_comb begin
    rd_mux = '0;
    for (int d = 0; d < DEPTH; d++) begin
      if (Rd_addr == AW'(d)) begin
        rd_mux = bank_reg[d];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux;
    end
  end

  assign Gnt     = gnt_reg;
  assign Ack     = ack_reg;
  assign Busy    = (state_reg == WRITE);
  assign Rd_data = rd_data_reg;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Shares one bank of DEPTH Width-bit D-flip-flop registers between NREQ independent write requesters.
- Uses round-robin arbitration with a per-requester Req/Gnt/Ack handshake, plus one registered read port.
- Sits between the producer blocks and the register storage, and is the only block allowed to write the bank.

Parameters:
- Width, 4, data width of each register
- NREQ, 4, number of write requesters (2..8)
- DEPTH, 4, number of registers in the bank
- AW, 2, address width; DEPTH must be no greater than 2**AW

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST  input  1  reset, active-high, asynchronous; clears all state immediately
- Req  input  NREQ  write request, one bit per requester
- Data_in  input  NREQ*Width  write data; requester i uses bits [i*Width +: Width]
- Addr_in  input  NREQ*AW  write address; requester i uses bits [i*AW +: AW]
- Clr  input  1  synchronous clear of the whole bank
- Rd_addr  input  AW  read address
- Gnt  output  NREQ  one-hot grant, registered
- Ack  output  NREQ  one-hot, single-cycle pulse marking write completion
- Busy  output  1  high while in the WRITE state
- Rd_data  output  Width  registered read data

Behaviour:
- Reset (asynchronous, RST=1):
  - bank all zeros; Gnt=0; Ack=0; Busy=0; Rd_data=0; state=IDLE
  - round-robin pointer ptr=NREQ-1, so requester 0 has first priority
- FSM has two states, IDLE and WRITE.
- IDLE:
  - If Req is nonzero, grant the first asserted requester searching ptr+1, ptr+2, ... with wrap modulo NREQ.
  - Next edge: Gnt = one-hot of the winner; latch the winner's Addr_in and Data_in into internal regs; Busy=1; go to WRITE.
  - If Req is zero, stay in IDLE with Gnt=0.
- WRITE (always exactly one cycle):
  - Next edge: bank[latched addr] <= latched data; Ack = Gnt; Gnt=0; Busy=0; ptr = winner index; go to IDLE.
- Throughput and latency:
  - One write per 2 cycles maximum.
  - Ack rises 2 edges after the winning Req is sampled.
- Handshake rules:
  - Data and address are captured on the grant edge. Requester changes after that edge, including dropping Req, do not affect the write in progress.
  - A requester that keeps Req high after its Ack is re-arbitrated and now has lowest priority.
- Out-of-range address: if latched addr >= DEPTH, the write is dropped but Ack still pulses.
- Clr:
  - Zeroes every register on the edge it is sampled.
  - If the same edge is a WRITE commit, Clr wins: the bank ends all zero and Ack still pulses.
  - Clr does not change FSM state, Gnt or ptr.
- Read port:
  - Rd_data <= bank[Rd_addr] every edge; out-of-range address returns 0.
  - Read and write to the same address on the same edge returns the pre-write value; the new value appears on the following edge.
  - Read and Clr on the same edge returns the pre-clear value.
- Reset mid-operation: RST asserted in WRITE aborts the write, no Ack is issued, and all state returns to reset values.
- Invariants:
  - Gnt and Ack are each zero or one-hot, and never both nonzero in the same cycle.
  - Busy equals (state==WRITE).

Test Plan:
- Reset: pulse RST asynchronously between edges -> all outputs 0 immediately; Rd_addr 0..3 each return 0 on following edges.
- Single write:
  - Stimulus: Req=0001, Addr_in[1:0]=2, Data_in[3:0]=4'hA.
  - Required: Gnt=0001 and Busy=1 after edge 1; Ack=0001 after edge 2; Rd_addr=2 gives Rd_data=4'hA one edge later.
- Full contention:
  - Stimulus: Req=1111 held, requester i writes addr i with data 4'h5+i.
  - Required: grant order 0,1,2,3,0 with one Ack every 2 cycles; bank reads 5,6,7,8.
- Round-robin fairness:
  - Stimulus: after requester 1 is served (ptr=1), set Req=1010.
  - Required: requester 3 is granted before requester 1.
- Reset in WRITE:
  - Stimulus: Req=0100, data 4'hF, RST asserted during the WRITE cycle.
  - Required: no Ack pulse; the target register reads 0; Gnt=0 and Busy=0.
- Clr collision:
  - Stimulus: Clr=1 on the WRITE commit edge, after registers were preloaded with 4'h3.
  - Required: all registers read 0; Ack pulses for the granted requester.
